// File: rtl/and_vector_pkg.sv
// -----------------------------------------------------------------------------
// and_vector_pkg
// Shared types, default sizing and the reference function for the AND-gate
// stimulus sequencer.
//   state_t        : sequencer FSM states (IDLE, DRIVE, DONE)
//   DEF_*          : default parameter values used by the sequencer top
//   MAX_N_INPUTS   : widest vector expected_and() can evaluate
//   expected_and() : reduction AND of a vector whose unused upper bits are 1
// -----------------------------------------------------------------------------
package and_vector_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    DRIVE = 2'd1,
    DONE  = 2'd2
  } state_t;

  localparam int DEF_N_INPUTS    = 2;
  localparam int DEF_HOLD_CYCLES = 100;
  localparam int DEF_CNT_W       = 8;
  localparam int MAX_N_INPUTS    = 32;

  // The caller pads bits above its own width with ones so they do not
  // influence the reduction; this keeps one function usable for any width.
  function automatic logic expected_and(input logic [MAX_N_INPUTS-1:0] vec);
    return &vec;
  endfunction

endpackage

// File: rtl/and_vector_sequencer_hold_timer.sv
// -----------------------------------------------------------------------------
// hold_timer
// Counts the cycles a vector has been held and flags the sample cycle.
//   clk   : rising-edge clock
//   rst   : synchronous active-high reset (count -> 0)
//   clear : forces the count to 0 (used whenever the sequencer is not driving)
//   en    : advance the count; it wraps to 0 after the sample cycle
//   last  : high when count == HOLD_CYCLES-1 (the sample cycle)
// -----------------------------------------------------------------------------
module hold_timer #(
  parameter int HOLD_CYCLES = 100
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic en,
  output logic last
);

  // A one-cycle hold still needs a 1-bit counter that simply stays at 0.
  localparam int W = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
  localparam logic [W-1:0] LAST_VAL = W'(HOLD_CYCLES - 1);

  logic [W-1:0] r_count;

  // NOTE: sequential state uses non-blocking assignments so every flop
  // samples the pre-edge value of every other flop.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_count <= '0;
    end else if (clear) begin
      r_count <= '0;
    end else if (en) begin
      if (last) r_count <= '0;
      else      r_count <= r_count + W'(1);
    end
  end

  assign last = (r_count == LAST_VAL);

endmodule

// File: rtl/and_vector_sequencer.sv
// -----------------------------------------------------------------------------
// and_vector_sequencer
// Synthesizable self-checking stimulus for an N-input AND gate. Drives every
// input combination in ascending order, holds each for HOLD_CYCLES cycles,
// samples the gate output on the last hold cycle and counts mismatches.
//
// Ports:
//   clk       : rising-edge clock
//   rst       : synchronous reset, active-high, overrides everything
//   start     : one-cycle pulse; begins a sweep from IDLE or DONE
//   vec_out   : vector driven to the gate (bit0 = a, bit1 = b, ...)
//   dut_out   : gate output, compared combinationally in the sample cycle
//   busy      : high while sweeping
//   done      : high from sweep end until next start or rst
//   pass      : valid with done; 1 iff err_count == 0
//   err_count : number of mismatching vectors, saturating
//   cur_idx   : index of the vector currently held (equals vec_out)
//
// Build option:
//   AND_VECTOR_SEQUENCER_STOP_ON_FAIL_EN - when defined, the first mismatch
//   ends the sweep on the next cycle with vec_out frozen on the failing vector.
// -----------------------------------------------------------------------------
module and_vector_sequencer
  import and_vector_pkg::*;
#(
  parameter int N_INPUTS    = DEF_N_INPUTS,
  parameter int HOLD_CYCLES = DEF_HOLD_CYCLES,
  parameter int CNT_W       = DEF_CNT_W
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start,
  output logic [N_INPUTS-1:0] vec_out,
  input  logic                dut_out,
  output logic                busy,
  output logic                done,
  output logic                pass,
  output logic [CNT_W-1:0]    err_count,
  output logic [N_INPUTS-1:0] cur_idx
);

  state_t                  r_state;
  logic [N_INPUTS-1:0]     r_vec;
  logic                    r_busy;
  logic                    r_done;
  logic                    r_pass;
  logic [CNT_W-1:0]        r_err;

  logic                    w_last;
  logic                    w_mismatch;
  logic                    w_last_vec;
  logic [CNT_W-1:0]        w_err_inc;
  logic [CNT_W-1:0]        w_err_next;
  logic [MAX_N_INPUTS-1:0] w_padded;

  // The hold counter only runs while driving and sits at 0 otherwise, so
  // every sweep starts with a full hold period on vector 0.
  hold_timer #(
    .HOLD_CYCLES (HOLD_CYCLES)
  ) u_hold_timer (
    .clk   (clk),
    .rst   (rst),
    .clear (r_state != DRIVE),
    .en    (r_state == DRIVE),
    .last  (w_last)
  );

  // NOTE: every variable written in always_comb gets a full default first,
  // otherwise partially assigned bits would infer latches.
  always_comb begin
    w_padded                = '1;
    w_padded[N_INPUTS-1:0]  = r_vec;
  end

  assign w_mismatch = (dut_out != expected_and(w_padded));
  assign w_last_vec = (r_vec == '1);
  assign w_err_inc  = (r_err == '1) ? r_err : r_err + CNT_W'(1);
  assign w_err_next = w_mismatch ? w_err_inc : r_err;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
      r_vec   <= '0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
      r_pass  <= 1'b0;
      r_err   <= '0;
    end else begin
      case (r_state)
        // IDLE and DONE share the start path; a restart from DONE behaves
        // exactly like a first start.
        IDLE, DONE: begin
          if (start) begin
            r_state <= DRIVE;
            r_vec   <= '0;
            r_busy  <= 1'b1;
            r_done  <= 1'b0;
            r_pass  <= 1'b0;
            r_err   <= '0;
          end
        end

        DRIVE: begin
          if (w_last) begin
            r_err <= w_err_next;
`ifdef AND_VECTOR_SEQUENCER_STOP_ON_FAIL_EN
            if (w_mismatch) begin
              // Freeze on the failing vector so it can be inspected.
              r_state <= DONE;
              r_busy  <= 1'b0;
              r_done  <= 1'b1;
              r_pass  <= 1'b0;
            end else if (w_last_vec) begin
              r_state <= DONE;
              r_busy  <= 1'b0;
              r_done  <= 1'b1;
              r_pass  <= (w_err_next == '0);
            end else begin
              r_vec <= r_vec + N_INPUTS'(1);
            end
`else
            // Last vector is detected before the increment, so r_vec
            // never wraps and stays all-ones in DONE.
            if (w_last_vec) begin
              r_state <= DONE;
              r_busy  <= 1'b0;
              r_done  <= 1'b1;
              r_pass  <= (w_err_next == '0);
            end else begin
              r_vec <= r_vec + N_INPUTS'(1);
            end
`endif
          end
        end

        default: begin
          r_state <= IDLE;
        end
      endcase
    end
  end

  assign vec_out   = r_vec;
  assign cur_idx   = r_vec;
  assign busy      = r_busy;
  assign done      = r_done;
  assign pass      = r_pass;
  assign err_count = r_err;

endmodule

// File: tb/tb_and_vector_sequencer.sv
// -----------------------------------------------------------------------------
// tb_and_vector_sequencer
// Directed bench for and_vector_sequencer with N_INPUTS=2, HOLD_CYCLES=4,
// CNT_W=8, plus a second instance with HOLD_CYCLES=1, CNT_W=1 driving an
// inverted gate to exercise one-cycle holds and counter saturation.
// Cycle k is the cycle following the k-th rising edge after start is raised;
// all driving and sampling happens on falling edges.
// -----------------------------------------------------------------------------
module tb_and_vector_sequencer;

  logic       clk;
  logic       rst;
  logic       start;
  logic [1:0] vec_out;
  logic       dut_out;
  logic       busy;
  logic       done;
  logic       pass;
  logic [7:0] err_count;
  logic [1:0] cur_idx;
  int         gate_mode;

  logic       start1;
  logic [1:0] vec1;
  logic       dut1_out;
  logic       busy1;
  logic       done1;
  logic       pass1;
  logic [0:0] err1;
  logic [1:0] idx1;

  int total = 0;
  int bad   = 0;

  and_vector_sequencer #(
    .N_INPUTS    (2),
    .HOLD_CYCLES (4),
    .CNT_W       (8)
  ) u_dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .vec_out   (vec_out),
    .dut_out   (dut_out),
    .busy      (busy),
    .done      (done),
    .pass      (pass),
    .err_count (err_count),
    .cur_idx   (cur_idx)
  );

  and_vector_sequencer #(
    .N_INPUTS    (2),
    .HOLD_CYCLES (1),
    .CNT_W       (1)
  ) u_dut1 (
    .clk       (clk),
    .rst       (rst),
    .start     (start1),
    .vec_out   (vec1),
    .dut_out   (dut1_out),
    .busy      (busy1),
    .done      (done1),
    .pass      (pass1),
    .err_count (err1),
    .cur_idx   (idx1)
  );

  // Gate models: 0 = AND, 1 = stuck-at-0, 2 = OR, 3 = stuck-at-1.
  always_comb begin
    case (gate_mode)
      0:       dut_out = &vec_out;
      1:       dut_out = 1'b0;
      2:       dut_out = |vec_out;
      default: dut_out = 1'b1;
    endcase
  end

  assign dut1_out = ~&vec1;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Full sweep on u_dut: start raised now, checks cycles 1..18.
  task automatic sweep(input int exp_err, input bit poke);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    check("start_err_clr",  32'(err_count), 0);
    check("start_done_low", 32'(done), 0);
    check("start_pass_low", 32'(pass), 0);
    for (int c = 1; c <= 16; c++) begin
      check("drive_vec",  32'(vec_out), 32'((c - 1) / 4));
      check("drive_idx",  32'(cur_idx), 32'((c - 1) / 4));
      check("drive_busy", 32'(busy), 1);
      check("drive_done", 32'(done), 0);
      start = poke && (c % 3 == 0);
      @(negedge clk);
    end
    start = 1'b0;
    check("end_done", 32'(done), 1);
    check("end_busy", 32'(busy), 0);
    check("end_err",  32'(err_count), 32'(exp_err));
    check("end_pass", 32'(pass), (exp_err == 0) ? 1 : 0);
    check("end_vec",  32'(vec_out), 3);
    @(negedge clk);
    check("hold_done", 32'(done), 1);
    check("hold_err",  32'(err_count), 32'(exp_err));
    check("hold_vec",  32'(vec_out), 3);
  endtask

  initial begin
    rst       = 1'b1;
    start     = 1'b0;
    start1    = 1'b0;
    gate_mode = 0;
    repeat (3) @(negedge clk);
    rst = 1'b0;

    // Reset values, then IDLE holding with start low.
    check("rst_vec",  32'(vec_out), 0);
    check("rst_busy", 32'(busy), 0);
    check("rst_done", 32'(done), 0);
    check("rst_pass", 32'(pass), 0);
    check("rst_err",  32'(err_count), 0);
    repeat (3) @(negedge clk);
    check("idle_busy", 32'(busy), 0);
    check("idle_vec",  32'(vec_out), 0);

    // Correct gate.
    gate_mode = 0;
    sweep(0, 1'b0);

    // Stuck-at-0: only vector 3 mismatches; restart from DONE.
    gate_mode = 1;
    sweep(1, 1'b0);

    // Restart from DONE with a good gate: err_count must clear.
    gate_mode = 0;
    sweep(0, 1'b0);

`ifdef AND_VECTOR_SEQUENCER_STOP_ON_FAIL_EN
    // Stuck-at-1: vector 0 fails, done five cycles after start.
    gate_mode = 3;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (3) @(negedge clk);
    check("sof_busy_c4", 32'(busy), 1);
    check("sof_done_c4", 32'(done), 0);
    @(negedge clk);
    check("sof_done", 32'(done), 1);
    check("sof_err",  32'(err_count), 1);
    check("sof_pass", 32'(pass), 0);
    check("sof_idx",  32'(cur_idx), 0);
    check("sof_vec",  32'(vec_out), 0);
`else
    // OR gate: vectors 1 and 2 mismatch.
    gate_mode = 2;
    sweep(2, 1'b0);
`endif

    // start pulses during DRIVE are ignored.
    gate_mode = 0;
    sweep(0, 1'b1);

    // rst at cycle 7 mid-sweep, restart at cycle 10, done at cycle 27.
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (6) @(negedge clk);
    check("mid_busy_c7", 32'(busy), 1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("mid_rst_vec",  32'(vec_out), 0);
    check("mid_rst_busy", 32'(busy), 0);
    check("mid_rst_done", 32'(done), 0);
    check("mid_rst_pass", 32'(pass), 0);
    check("mid_rst_err",  32'(err_count), 0);
    @(negedge clk);
    check("mid_idle_busy", 32'(busy), 0);
    @(negedge clk);
    sweep(0, 1'b0);

    // One-cycle hold with a 1-bit saturating counter and an inverted gate.
    start1 = 1'b1;
    @(negedge clk);
    start1 = 1'b0;
    check("h1_busy_c1", 32'(busy1), 1);
    check("h1_vec_c1",  32'(vec1), 0);
`ifdef AND_VECTOR_SEQUENCER_STOP_ON_FAIL_EN
    @(negedge clk);
    check("h1_done", 32'(done1), 1);
    check("h1_err",  32'(err1), 1);
    check("h1_pass", 32'(pass1), 0);
    check("h1_vec",  32'(vec1), 0);
`else
    @(negedge clk);
    check("h1_vec_c2", 32'(vec1), 1);
    repeat (3) @(negedge clk);
    check("h1_done", 32'(done1), 1);
    check("h1_busy", 32'(busy1), 0);
    check("h1_err_sat", 32'(err1), 1);
    check("h1_pass", 32'(pass1), 0);
    check("h1_vec",  32'(vec1), 3);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
